// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: parametrised stall/flush controller with load-use tracker and I-cache resume FSM.
// Optional HAZARD_PERF_CNT_EN adds saturating load-hazard, D-cache and I-cache stall cycle counters.
module hazard_scoreboard #(
  parameter int NUM_STAGES   = 5,
  parameter int REG_AW       = 5,
  parameter int DATA_STAGE   = 4,
  parameter int BRANCH_STAGE = 3,
  parameter int DCACHE_STAGE = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_RS1Valid_ID,
  input  logic [REG_AW-1:0]     i_RS1Addr_ID,
  input  logic                  i_RS2Valid_ID,
  input  logic [REG_AW-1:0]     i_RS2Addr_ID,
  input  logic [REG_AW-1:0]     i_RDAddr_ID,
  input  logic                  i_IsMemRead_ID,
  input  logic                  i_TakeBranch,
  input  logic                  i_ICacheStall,
  input  logic                  i_DCacheStall,
  output logic                  o_PcEn,
  output logic                  o_IBusRdEn,
  output logic                  o_ICacheHoldOut,
  output logic [NUM_STAGES-1:0] o_StageEn,
  output logic [NUM_STAGES-1:0] o_StageClr,
  output logic                  o_LoadHaz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           o_LoadHazCycles,
  output logic [31:0]           o_DCacheCycles,
  output logic [31:0]           o_ICacheCycles
`endif
);
  localparam int TRK = DATA_STAGE - 1;
  typedef enum logic [1:0] {RUN, ICWAIT, RESUME} state_t;
  state_t r_State, nextState;
  logic r_PrevHaz, loadHaz, icIdle, brRow, pcEn, iBusEn;
  logic [NUM_STAGES-1:0] stageEn, stageClr;
  logic r_TrkValid [TRK];
  logic [REG_AW-1:0] r_TrkRd [TRK];
  logic shInValid [TRK];
  logic [REG_AW-1:0] shInRd [TRK];
  // Entry j tracks pipeline stage j+2; entry 0 is fed from ID.
  assign shInValid[0] = i_IsMemRead_ID && i_RDAddr_ID != '0;
  assign shInRd[0] = i_RDAddr_ID;
  for (genvar k = 1; k < TRK; k++) begin : g_shift
    assign shInValid[k] = r_TrkValid[k-1];
    assign shInRd[k] = r_TrkRd[k-1];
  end
  always_comb begin
    loadHaz = 1'b0;
    for (int j = 0; j < TRK; j++)
      loadHaz = loadHaz | (r_TrkValid[j] &&
        ((i_RS1Valid_ID && i_RS1Addr_ID != '0 && r_TrkRd[j] == i_RS1Addr_ID) ||
         (i_RS2Valid_ID && i_RS2Addr_ID != '0 && r_TrkRd[j] == i_RS2Addr_ID)));
  end
  assign icIdle = r_State != ICWAIT && !i_ICacheStall;
  assign brRow = !i_DCacheStall && i_TakeBranch && icIdle;
  // Rows are mutually exclusive so a lower row never bubbles a stage a higher row is holding.
  always_comb begin
    pcEn = 1'b1;
    iBusEn = 1'b1;
    stageEn = '1;
    stageClr = '0;
    if (i_DCacheStall) begin
      stageEn[DCACHE_STAGE:0] = '0;
      pcEn = 1'b0;
      iBusEn = 1'b0;
      stageClr[DCACHE_STAGE+1] = 1'b1;
    end else if (brRow) begin
      stageClr[BRANCH_STAGE:0] = '1;
    end else if (i_TakeBranch) begin
      stageEn[BRANCH_STAGE:0] = '0;
      pcEn = 1'b0;
    end else if (loadHaz) begin
      stageEn[1:0] = '0;
      pcEn = 1'b0;
      iBusEn = 1'b0;
      stageClr[2] = 1'b1;
    end else if (r_State == ICWAIT) begin
      pcEn = 1'b0;
      stageEn[0] = 1'b0;
      stageClr[1] = 1'b1;
    end else if (r_State == RESUME && !r_PrevHaz) begin
      stageClr[1] = 1'b1;
    end
  end
  always_comb
    nextState = i_ICacheStall ? ICWAIT :
                r_State == RUN ? RUN :
                r_State == ICWAIT ? RESUME :
                (brRow || !(i_DCacheStall || loadHaz || r_PrevHaz)) ? RUN : RESUME;
  assign o_PcEn = !i_Rst && pcEn;
  assign o_IBusRdEn = !i_Rst && iBusEn;
  assign o_ICacheHoldOut = !i_Rst && r_State == RESUME && (loadHaz || r_PrevHaz);
  assign o_StageEn = i_Rst ? '0 : stageEn;
  assign o_StageClr = i_Rst ? '1 : stageClr;
  assign o_LoadHaz = !i_Rst && loadHaz;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= RUN;
      r_PrevHaz <= 1'b0;
      for (int j = 0; j < TRK; j++) begin
        r_TrkValid[j] <= 1'b0;
        r_TrkRd[j] <= '0;
      end
    end else begin
      r_State <= nextState;
      r_PrevHaz <= loadHaz;
      for (int j = 0; j < TRK; j++) begin
        if (stageClr[j+2]) r_TrkValid[j] <= 1'b0;
        else if (stageEn[j+2]) begin
          r_TrkValid[j] <= shInValid[j];
          r_TrkRd[j] <= shInRd[j];
        end
      end
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_LoadHazCycles <= '0;
      o_DCacheCycles <= '0;
      o_ICacheCycles <= '0;
    end else begin
      if (!i_DCacheStall && !i_TakeBranch && loadHaz && o_LoadHazCycles != '1) o_LoadHazCycles <= o_LoadHazCycles + 32'd1;
      if (i_DCacheStall && o_DCacheCycles != '1) o_DCacheCycles <= o_DCacheCycles + 32'd1;
      if (r_State == ICWAIT && o_ICacheCycles != '1) o_ICacheCycles <= o_ICacheCycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stalls, flushes, tracker and I-cache resume with default parameters.
module tb_hazard_scoreboard;
  logic i_Clk = 1'b0;
  logic i_Rst, i_RS1Valid_ID, i_RS2Valid_ID, i_IsMemRead_ID, i_TakeBranch, i_ICacheStall, i_DCacheStall;
  logic [4:0] i_RS1Addr_ID, i_RS2Addr_ID, i_RDAddr_ID;
  logic o_PcEn, o_IBusRdEn, o_ICacheHoldOut, o_LoadHaz;
  logic [4:0] o_StageEn, o_StageClr;
  int checks = 0;
  int errors = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] o_LoadHazCycles, o_DCacheCycles, o_ICacheCycles;
`endif
  hazard_scoreboard dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_RS1Valid_ID(i_RS1Valid_ID), .i_RS1Addr_ID(i_RS1Addr_ID),
    .i_RS2Valid_ID(i_RS2Valid_ID), .i_RS2Addr_ID(i_RS2Addr_ID),
    .i_RDAddr_ID(i_RDAddr_ID), .i_IsMemRead_ID(i_IsMemRead_ID),
    .i_TakeBranch(i_TakeBranch), .i_ICacheStall(i_ICacheStall), .i_DCacheStall(i_DCacheStall),
    .o_PcEn(o_PcEn), .o_IBusRdEn(o_IBusRdEn), .o_ICacheHoldOut(o_ICacheHoldOut),
    .o_StageEn(o_StageEn), .o_StageClr(o_StageClr), .o_LoadHaz(o_LoadHaz)
`ifdef HAZARD_PERF_CNT_EN
    , .o_LoadHazCycles(o_LoadHazCycles), .o_DCacheCycles(o_DCacheCycles), .o_ICacheCycles(o_ICacheCycles)
`endif
  );
  always #5 i_Clk = ~i_Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    i_RS1Valid_ID = 0; i_RS1Addr_ID = 0; i_RS2Valid_ID = 0; i_RS2Addr_ID = 0;
    i_RDAddr_ID = 0; i_IsMemRead_ID = 0; i_TakeBranch = 0; i_ICacheStall = 0; i_DCacheStall = 0;
  endtask
  task automatic nxt();
    @(negedge i_Clk);
  endtask
  task automatic load(input logic [4:0] rd);
    idle(); i_IsMemRead_ID = 1; i_RDAddr_ID = rd;
  endtask
  task automatic use1(input logic [4:0] rs);
    idle(); i_RS1Valid_ID = 1; i_RS1Addr_ID = rs; i_RDAddr_ID = 5'd6;
  endtask
  task automatic chkDefaults(input string tag);
    chk({tag, "_en"}, o_StageEn, 5'h1F);
    chk({tag, "_clr"}, o_StageClr, 5'h00);
    chk({tag, "_pc"}, o_PcEn, 1'b1);
    chk({tag, "_ibus"}, o_IBusRdEn, 1'b1);
  endtask
  initial begin
    idle();
    i_Rst = 1;
    #1;
    chk("rst_clr", o_StageClr, 5'h1F);
    chk("rst_en", o_StageEn, 5'h00);
    chk("rst_pc", o_PcEn, 1'b0);
    chk("rst_ibus", o_IBusRdEn, 1'b0);
    chk("rst_haz", o_LoadHaz, 1'b0);
    chk("rst_hold", o_ICacheHoldOut, 1'b0);
    nxt(); nxt();
    i_Rst = 0; #1;
    chkDefaults("idle");
    // load x5 then consumer of x5: three hazard cycles, then advance
    nxt(); load(5'd5); #1;
    chk("lu_load_haz", o_LoadHaz, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nxt(); use1(5'd5); #1;
      chk("lu_haz", o_LoadHaz, 1'b1);
      chk("lu_clr", o_StageClr, 5'b00100);
      chk("lu_en", o_StageEn, 5'b11100);
      chk("lu_pc", o_PcEn, 1'b0);
      chk("lu_ibus", o_IBusRdEn, 1'b0);
    end
    nxt(); use1(5'd5); #1;
    chk("lu_done_haz", o_LoadHaz, 1'b0);
    chkDefaults("lu_done");
    // load x0 then read x0 on both sources: never a hazard
    nxt(); load(5'd0); #1;
    chk("x0_load", o_LoadHaz, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nxt(); use1(5'd0); i_RS2Valid_ID = 1; #1;
      chk("x0_haz", o_LoadHaz, 1'b0);
      chk("x0_pc", o_PcEn, 1'b1);
    end
    // D-cache stall with x5 load parked at stage 2
    nxt(); load(5'd5); #1;
    for (int i = 0; i < 4; i++) begin
      nxt(); idle(); i_RS2Valid_ID = 1; i_RS2Addr_ID = 5'd5; i_DCacheStall = 1; #1;
      chk("dc_en", o_StageEn, 5'b10000);
      chk("dc_clr", o_StageClr, 5'b10000);
      chk("dc_pc", o_PcEn, 1'b0);
      chk("dc_ibus", o_IBusRdEn, 1'b0);
      chk("dc_haz", o_LoadHaz, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      nxt(); idle(); i_RS2Valid_ID = 1; i_RS2Addr_ID = 5'd5; #1;
      chk("dc_rel_haz", o_LoadHaz, 1'b1);
      chk("dc_rel_clr", o_StageClr, 5'b00100);
    end
    nxt(); idle(); i_RS2Valid_ID = 1; i_RS2Addr_ID = 5'd5; #1;
    chk("dc_rel_done", o_LoadHaz, 1'b0);
    // branch waiting on a 6-cycle I-cache miss
    nxt(); idle(); i_ICacheStall = 1; #1;
    chkDefaults("br_miss_start");
    for (int i = 0; i < 6; i++) begin
      nxt(); idle(); i_TakeBranch = 1; i_ICacheStall = (i < 5); #1;
      chk("br_wait_en", o_StageEn, 5'b10000);
      chk("br_wait_pc", o_PcEn, 1'b0);
      chk("br_wait_clr", o_StageClr, 5'b00000);
    end
    nxt(); idle(); i_TakeBranch = 1; #1;
    chk("br_flush_clr", o_StageClr, 5'b01111);
    chk("br_flush_pc", o_PcEn, 1'b1);
    nxt(); idle(); #1;
    chkDefaults("br_after");
    // 3-cycle I-cache miss overlapping a load hazard
    nxt(); load(5'd5); i_ICacheStall = 1; #1;
    chkDefaults("ic_c0");
    for (int i = 0; i < 3; i++) begin
      nxt(); use1(5'd5); i_ICacheStall = (i < 2); #1;
      chk("ic_haz", o_LoadHaz, 1'b1);
      chk("ic_haz_clr", o_StageClr, 5'b00100);
      chk("ic_haz_en", o_StageEn, 5'b11100);
      chk("ic_haz_hold", o_ICacheHoldOut, 1'b0);
    end
    nxt(); use1(5'd5); #1;
    chk("ic_c4_haz", o_LoadHaz, 1'b0);
    chk("ic_c4_hold", o_ICacheHoldOut, 1'b1);
    chk("ic_c4_clr", o_StageClr, 5'b00000);
    chk("ic_c4_en", o_StageEn, 5'h1F);
    nxt(); idle(); #1;
    chk("ic_c5_hold", o_ICacheHoldOut, 1'b0);
    chk("ic_c5_clr", o_StageClr, 5'b00010);
    nxt(); idle(); #1;
    chkDefaults("ic_c6");
    chk("ic_c6_hold", o_ICacheHoldOut, 1'b0);
    // async reset in the middle of a D-cache stall
    nxt(); load(5'd5); #1;
    nxt(); use1(5'd5); i_DCacheStall = 1; #1;
    chk("rs_dc_en", o_StageEn, 5'b10000);
    #1 i_Rst = 1;
    #1;
    chk("rs_async_clr", o_StageClr, 5'h1F);
    chk("rs_async_en", o_StageEn, 5'h00);
    chk("rs_async_pc", o_PcEn, 1'b0);
    chk("rs_async_haz", o_LoadHaz, 1'b0);
    nxt(); nxt();
    use1(5'd5); i_Rst = 0; #1;
    chk("rs_rel_haz", o_LoadHaz, 1'b0);
    chk("rs_rel_hold", o_ICacheHoldOut, 1'b0);
    chkDefaults("rs_rel");
    nxt(); idle(); #1;
    chkDefaults("rs_run");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised pipeline hazard controller for the in-order CPU; successor to the fixed 5-stage stall/flush logic.
- Generalises stage count, load-data-ready stage, branch-resolve stage and D-cache stage.
- Holds a load-destination tracker shift register and an I-cache resume FSM. Drives PC, I-bus and per-stage register enable/clear vectors.

Parameters:
- NUM_STAGES, 5: pipeline registers; index 0=IF, 1=ID, 2=EX1, ...
- REG_AW, 5: register address width; x0 is never a hazard.
- DATA_STAGE, 4: stage index at which load data becomes forwardable. Loads are tracked in stages 2..DATA_STAGE; range 2..NUM_STAGES-1.
- BRANCH_STAGE, 3: stage that resolves taken branches/jumps; range 2..NUM_STAGES-1.
- DCACHE_STAGE, 3: stage that raises D-cache stall; range 2..NUM_STAGES-2.

Ports:
- i_Clk  in  1  clock; all state on rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_RS1Valid_ID  in  1  ID uses RS1.
- i_RS1Addr_ID  in  REG_AW  RS1 address.
- i_RS2Valid_ID  in  1  ID uses RS2.
- i_RS2Addr_ID  in  REG_AW  RS2 address.
- i_RDAddr_ID  in  REG_AW  ID destination.
- i_IsMemRead_ID  in  1  ID holds a load.
- i_TakeBranch  in  1  taken branch/jump at BRANCH_STAGE.
- i_ICacheStall  in  1  I-cache miss in progress.
- i_DCacheStall  in  1  D-cache miss at DCACHE_STAGE.
- o_PcEn  out  1  PC update enable.
- o_IBusRdEn  out  1  I-bus read enable.
- o_ICacheHoldOut  out  1  I-cache holds its output word.
- o_StageEn  out  NUM_STAGES  per-stage register enable.
- o_StageClr  out  NUM_STAGES  per-stage synchronous clear (bubble); clear overrides enable.
- o_LoadHaz  out  1  load-use hazard detected this cycle (debug/perf).

Behaviour:
- Reset: i_Rst high asynchronously clears the tracker, puts the FSM in RUN and clears r_PrevHaz.
  - While i_Rst is high, outputs are forced: o_PcEn=0, o_IBusRdEn=0, o_ICacheHoldOut=0, o_StageEn=0, o_StageClr=all 1s, o_LoadHaz=0.
  - Reset asserted mid-stall drops every stall at once; the first cycle after release is RUN with default outputs.
- Defaults (all outputs combinational from state and inputs):
  - o_PcEn=1, o_IBusRdEn=1, o_ICacheHoldOut=0.
  - o_StageEn=all 1s, o_StageClr=0.
- Tracker:
  - Holds entries {valid, rd} for stages 2..DATA_STAGE.
  - Entry 2 loads {i_IsMemRead_ID & (i_RDAddr_ID!=0), i_RDAddr_ID} when stage 2 is enabled and not cleared.
  - Entry k loads entry k-1 when o_StageEn[k]; holds otherwise.
  - Entry k is invalidated when o_StageClr[k].
  - o_LoadHaz = any valid entry whose rd equals a valid, non-zero RS1/RS2.
- Priority, highest first; later rows only touch bits not set by earlier rows:
  - 1. D-cache stall (i_DCacheStall): o_StageEn[0..DCACHE_STAGE]=0, o_PcEn=0, o_IBusRdEn=0, o_StageClr[DCACHE_STAGE+1]=1 every stall cycle. Tracker frozen except a clear at index DCACHE_STAGE+1 if that index is tracked.
  - 2. Taken branch, I-cache idle (FSM RUN/RESUME and !i_ICacheStall): o_StageClr[0..BRANCH_STAGE]=1, o_PcEn=1. The branch is lost if not taken that cycle, so BRANCH_STAGE holds it.
  - 3. Taken branch, I-cache busy: o_StageEn[0..BRANCH_STAGE]=0 and o_PcEn=0 until the I-cache is idle, then row 2 applies.
  - 4. Load hazard: o_StageEn[0..1]=0, o_PcEn=0, o_IBusRdEn=0, o_StageClr[2]=1.
  - 5. I-cache FSM outputs below.
- I-cache FSM:
  - RUN: i_ICacheStall -> ICWAIT.
  - ICWAIT: o_PcEn=0, o_StageEn[0]=0, o_StageClr[1]=1 (bubble to ID), downstream stages run. Goes to RESUME when !i_ICacheStall.
  - RESUME: if o_LoadHaz or r_PrevHaz, assert o_ICacheHoldOut=1 and stay. Otherwise assert o_StageClr[1]=1 to drop the duplicated fetch and go to RUN. If i_ICacheStall re-asserts -> ICWAIT.
  - Branch flush (row 2) in RESUME -> RUN.
- r_PrevHaz: registered o_LoadHaz.
- Simultaneous D-cache stall and I-cache stall: FSM still advances on the I-cache condition; stage outputs follow row 1.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN. When defined, adds three 32-bit outputs:
  - o_LoadHazCycles: counts cycles with row 4 active.
  - o_DCacheCycles: counts cycles with row 1 active.
  - o_ICacheCycles: counts cycles in ICWAIT.
- Counters saturate at 0xFFFFFFFF and are async-cleared by i_Rst.
- When undefined, ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load x5 in ID, next ID reads RS1=x5, defaults (DATA_STAGE=4) -> o_LoadHaz=1 for 3 cycles, o_StageClr[2] pulses each cycle, o_PcEn=0, then the consumer advances.
- Load x0 followed by a read of x0 -> no stall; o_LoadHaz=0 throughout.
- i_DCacheStall high 4 cycles -> o_StageEn[3:0]=0 and o_StageClr[4]=1 for exactly 4 cycles; tracker contents unchanged on release.
- i_TakeBranch while i_ICacheStall high 6 cycles -> o_StageEn[3:0]=0 for 6 cycles, then one cycle with o_StageClr[3:0]=4'hF and o_PcEn=1.
- I-cache miss of 3 cycles with load hazard active at release -> FSM path ICWAIT, RESUME; o_ICacheHoldOut=1 until the hazard clears, then RUN; no instruction lost or duplicated.
- i_Rst asserted mid D-cache stall -> o_StageClr=all 1s immediately (async), tracker empty, RUN one cycle after release.
